ret_pred_checker: RTL and testbench

Verifies return-address predictions at retirement, acting as the reader/consumer of the return stack's fetch-time predictions. Fetch enqueues each return's predicted target, whether or not the prediction is valid. At retirement the oldest entry is dequeued and compared with the actual return target. A mismatch raises a registered mispredict pulse with the correct redirect PC, and the block then waits in a drain state until the pipeline squash arrives.

---
 rtl/ret_pred_checker_pkg.sv | 22 ++
 rtl/ret_pred_checker_if.sv | 37 +++
 rtl/ret_pred_checker_sat_counter.sv | 26 ++
 rtl/ret_pred_checker.sv | 130 +++++++++++++
 tb/tb_ret_pred_checker.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ret_pred_checker_pkg.sv
// Shared definitions for the return-prediction checker.
//   DEF_RPQ_SIZE / DEF_STAT_W : default queue depth and statistics width
//   RAS_SIZE                  : depth of the return stack feeding this queue
//   RPQ_ENTRY                 : one queued prediction {pvalid, pc}
//   RPQ_STATE                 : checker state (RUN / DRAIN)
package ret_pred_checker_pkg;

  localparam int unsigned DEF_RPQ_SIZE = 8;
  localparam int unsigned DEF_STAT_W   = 16;
  localparam int unsigned RAS_SIZE     = 16;

  typedef struct packed {
    logic        pvalid;
    logic [31:0] pc;
  } RPQ_ENTRY;

  typedef enum logic {
    RPQ_RUN,
    RPQ_DRAIN
  } RPQ_STATE;

endpackage

// File: rtl/ret_pred_checker_if.sv
// Fetch/retire/result bundle of the return-prediction checker.
//   master : fetch + retire + squash producer (pipeline side)
//   slave  : the checker itself
interface ret_pred_checker_if #(
  parameter int unsigned RPQ_SIZE = 8,
  parameter int unsigned STAT_W   = 16
);

  logic                        fetch_ret_valid;
  logic                        fetch_pred_valid;
  logic [31:0]                 fetch_pred_pc;
  logic                        enq_ready;
  logic                        retire_ret_valid;
  logic [31:0]                 retire_target;
  logic                        squash;
  logic                        mispredict_out;
  logic [31:0]                 redirect_pc;
  logic [$clog2(RPQ_SIZE):0]   count_out;
  logic                        underflow_err;
  logic [STAT_W-1:0]           hit_count;
  logic [STAT_W-1:0]           miss_count;

  modport master (
    output fetch_ret_valid, fetch_pred_valid, fetch_pred_pc,
    output retire_ret_valid, retire_target, squash,
    input  enq_ready, mispredict_out, redirect_pc, count_out,
    input  underflow_err, hit_count, miss_count
  );

  modport slave (
    input  fetch_ret_valid, fetch_pred_valid, fetch_pred_pc,
    input  retire_ret_valid, retire_target, squash,
    output enq_ready, mispredict_out, redirect_pc, count_out,
    output underflow_err, hit_count, miss_count
  );

endinterface

// File: rtl/ret_pred_checker_sat_counter.sv
// Saturating up-counter used for hit/miss statistics.
//   clock, reset : rising-edge clock, async active-low reset
//   inc          : count up by one (holds at all-ones)
//   clear        : synchronous clear to zero
//   count        : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ret_pred_checker.sv
// Return-address prediction checker. Fetch enqueues every return's predicted
// target; at retirement the oldest entry is compared with the real target.
// A miss flushes the queue, pulses mispredict_out with redirect_pc one cycle
// later, and holds the block in DRAIN until the pipeline squash arrives.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : ret_pred_checker_if slave (fetch, retire, squash, results)
module ret_pred_checker
  import ret_pred_checker_pkg::*;
#(
  parameter int unsigned RPQ_SIZE = DEF_RPQ_SIZE,
  parameter int unsigned STAT_W   = DEF_STAT_W
) (
  input  logic             clock,
  input  logic             reset,
  ret_pred_checker_if.slave bus
);

  localparam int unsigned PW = $clog2(RPQ_SIZE);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RPQ_SIZE);

  RPQ_ENTRY          r_mem [RPQ_SIZE];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  RPQ_STATE          r_state;
  logic              r_mispredict;
  logic [31:0]       r_redirect;
  logic              r_underflow;

  RPQ_ENTRY          w_head_e;
  logic              w_run;
  logic              w_enq_ready;
  logic              w_enq;
  logic              w_ret;
  logic              w_hit;
  logic              w_miss;
  logic              w_underflow;
  logic              w_flush;
  logic [STAT_W-1:0] w_hit_count;
  logic [STAT_W-1:0] w_miss_count;

  always_comb begin
    w_head_e    = r_mem[r_head];
    w_run       = (r_state == RPQ_RUN);
    // Registered count only: a same-cycle pop never frees a slot.
    w_enq_ready = w_run && (r_count != FULL);
    w_enq       = bus.fetch_ret_valid && w_enq_ready;
    w_ret       = bus.retire_ret_valid && w_run && (r_count != '0);
    w_underflow = bus.retire_ret_valid && w_run && (r_count == '0);
    w_hit       = w_ret && w_head_e.pvalid && (w_head_e.pc == bus.retire_target);
    w_miss      = w_ret && !w_hit;
    // Retire is judged before squash, but either one empties the queue and
    // discards any same-cycle enqueue.
    w_flush     = w_miss || bus.squash;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RPQ_SIZE; i++) begin
        r_mem[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= RPQ_RUN;
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_mispredict <= w_miss;
      if (w_miss) begin
        r_redirect <= bus.retire_target;
      end
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end

      if (bus.squash) begin
        r_state <= RPQ_RUN;
      end else if (w_miss) begin
        r_state <= RPQ_DRAIN;
      end

      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) begin
          r_mem[r_tail] <= '{pvalid: bus.fetch_pred_valid, pc: bus.fetch_pred_pc};
          r_tail        <= r_tail + 1'b1;
        end
        if (w_hit) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_enq, w_hit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_hit),
    .clear (1'b0),
    .count (w_hit_count)
  );

  sat_counter #(.W(STAT_W)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_miss),
    .clear (1'b0),
    .count (w_miss_count)
  );

  assign bus.enq_ready      = w_enq_ready;
  assign bus.mispredict_out = r_mispredict;
  assign bus.redirect_pc    = r_redirect;
  assign bus.count_out      = r_count;
  assign bus.underflow_err  = r_underflow;
  assign bus.hit_count      = w_hit_count;
  assign bus.miss_count     = w_miss_count;

endmodule

// File: tb/tb_ret_pred_checker.sv
// Self-checking bench for ret_pred_checker: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// STAT_W is reduced so counter saturation is reached within the run.
module tb_ret_pred_checker;

  localparam int unsigned RPQ_SIZE = 8;
  localparam int unsigned STAT_W   = 6;
  localparam int unsigned SMAX     = (1 << STAT_W) - 1;

  typedef struct {
    bit        pv;
    bit [31:0] pc;
  } ent_t;

  logic clk;
  logic rst_n;

  ret_pred_checker_if #(.RPQ_SIZE(RPQ_SIZE), .STAT_W(STAT_W)) bus ();

  ret_pred_checker #(.RPQ_SIZE(RPQ_SIZE), .STAT_W(STAT_W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t        q[$];
  bit          m_drain;
  bit          m_under;
  bit          m_mis;
  bit [31:0]   m_red;
  int unsigned m_hits;
  int unsigned m_miss;

  int unsigned n_vec;
  int unsigned n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_drain = 1'b0;
    m_under = 1'b0;
    m_mis   = 1'b0;
    m_red   = '0;
    m_hits  = 0;
    m_miss  = 0;
  endfunction

  task automatic check_all();
    chk("count_out", 32'(bus.count_out), q.size());
    chk("enq_ready", 32'(bus.enq_ready), 32'(!m_drain && (q.size() < RPQ_SIZE)));
    chk("mispredict_out", 32'(bus.mispredict_out), 32'(m_mis));
    if (m_mis) chk("redirect_pc", bus.redirect_pc, m_red);
    chk("underflow_err", 32'(bus.underflow_err), 32'(m_under));
    chk("hit_count", 32'(bus.hit_count), m_hits);
    chk("miss_count", 32'(bus.miss_count), m_miss);
  endtask

  task automatic drive_idle();
    bus.fetch_ret_valid  = 1'b0;
    bus.fetch_pred_valid = 1'b0;
    bus.fetch_pred_pc    = '0;
    bus.retire_ret_valid = 1'b0;
    bus.retire_target    = '0;
    bus.squash           = 1'b0;
  endtask

  // One clock: check outputs at negedge, drive inputs, advance the model
  // to what the next rising edge should produce.
  task automatic step(input bit fv, input bit pv, input bit [31:0] ppc,
                      input bit rv, input bit [31:0] tgt, input bit sq);
    bit ready;
    bit miss;
    @(negedge clk);
    check_all();
    bus.fetch_ret_valid  = fv;
    bus.fetch_pred_valid = pv;
    bus.fetch_pred_pc    = ppc;
    bus.retire_ret_valid = rv;
    bus.retire_target    = tgt;
    bus.squash           = sq;

    ready = !m_drain && (q.size() < RPQ_SIZE);
    miss  = 1'b0;
    m_mis = 1'b0;
    if (!m_drain && rv) begin
      if (q.size() == 0) begin
        m_under = 1'b1;
      end else if (q[0].pv && (q[0].pc == tgt)) begin
        void'(q.pop_front());
        if (m_hits < SMAX) m_hits++;
      end else begin
        miss  = 1'b1;
        m_mis = 1'b1;
        m_red = tgt;
        if (m_miss < SMAX) m_miss++;
      end
    end
    if (miss || sq) q.delete();
    else if (fv && ready) q.push_back('{pv: pv, pc: ppc});
    if (sq) m_drain = 1'b0;
    else if (miss) m_drain = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_step();
    bit        fv, pv, rv, sq;
    bit [31:0] ppc, tgt;
    fv  = ($urandom_range(3) != 0);
    pv  = ($urandom_range(7) != 0);
    ppc = {20'h0, 10'($urandom_range(1023)), 2'b00};
    rv  = ($urandom_range(2) == 0);
    if ((q.size() > 0) && ($urandom_range(5) != 0)) tgt = q[0].pc;
    else tgt = {20'h0, 10'($urandom_range(1023)), 2'b00};
    sq  = ($urandom_range(15) == 0);
    step(fv, pv, ppc, rv, tgt, sq);
  endtask

  // Assert reset asynchronously between edges and check it takes effect at once.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two hits in order
    step(1, 1, 32'h100, 0, 0, 0);
    step(1, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 1, 32'h200, 0);
    idle();

    // Wrong target -> miss, drain until squash; traffic during drain ignored
    step(1, 1, 32'h400, 0, 0, 0);
    step(0, 0, 0, 1, 32'h404, 0);
    idle();
    step(1, 1, 32'h800, 0, 0, 0);
    step(0, 0, 0, 1, 32'h800, 0);
    step(0, 0, 0, 0, 0, 1);
    idle();

    // Invalid prediction always misses
    step(1, 0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1);
    idle();

    // Fill to full, enqueue+hit at full, drain; twice for pointer wrap
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned k = 0; k < RPQ_SIZE; k++)
        step(1, 1, 32'h1000 + 32'(r * 256 + k * 4), 0, 0, 0);
      step(1, 1, 32'h9000, 0, 0, 0);
      step(1, 1, 32'h9004, 1, 32'h1000 + 32'(r * 256), 0);
      for (int unsigned k = 1; k < RPQ_SIZE; k++)
        step(0, 0, 0, 1, 32'h1000 + 32'(r * 256 + k * 4), 0);
      idle();
    end

    // Underflow is sticky and does not mispredict
    step(0, 0, 0, 1, 32'h1234, 0);
    idle();
    idle();

    // Miss together with squash -> pulse but stays in RUN
    step(1, 1, 32'h500, 0, 0, 0);
    step(1, 1, 32'h600, 1, 32'h504, 1);
    idle();
    idle();

    // Randomized traffic (also drives the counters into saturation)
    for (int unsigned i = 0; i < 3000; i++) rand_step();
    step(0, 0, 0, 0, 0, 1);

    // Reset mid-queue
    step(1, 1, 32'h700, 0, 0, 0);
    step(1, 1, 32'h704, 0, 0, 0);
    step(1, 1, 32'h708, 0, 0, 0);
    async_reset();
    idle();

    // Reset while the mispredict pulse is showing
    step(1, 1, 32'hA00, 0, 0, 0);
    step(0, 0, 0, 1, 32'hA04, 0);
    async_reset();
    idle();

    for (int unsigned i = 0; i < 200; i++) rand_step();
    @(negedge clk);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
